// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Fetch sequencer states: BOOT loads the reset PC, RUN fetches, FLUSH absorbs a redirect.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES        = 4;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    // One buffered instruction: the address it was fetched from plus the word itself.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the byte offset so fetch always restarts on a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; head is read from registered storage.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             pop_eff;
    logic             push_eff;

    // Popping an empty buffer is a no-op; a push into a full buffer only lands if a pop frees a slot.
    assign pop_eff  = pop && (count_reg != '0);
    assign push_eff = push && ((count_reg != CW'(DEPTH)) || pop_eff);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Each slot captures the pushed word when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (push_eff && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count      = count_reg;
    assign head_valid = (count_reg != '0);
    assign head_data  = entries[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: steers the external PC register, issues memory reads, buffers results for decode.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_t state_reg;
    logic         inflight_reg;
    logic [31:0]  tag_reg;
    logic         misalign_reg;

    logic [CW-1:0] fifo_count;
    logic          fifo_valid;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          redirect_take;
    logic          pop;
    logic          accept;
    logic          push;
    logic [OW-1:0] occupancy;

    // Redirects are only honoured once the PC has been seeded, i.e. outside BOOT.
    assign redirect_take = redirect_valid && (state_reg != BOOT) && !reset;
    assign pop           = fifo_valid && inst_ready;

    // Slots already claimed: buffered entries plus a read in flight, minus the one leaving now.
    assign occupancy = OW'(fifo_count) + OW'(inflight_reg) - OW'(pop);

    assign imem_req  = !reset && (state_reg == RUN) && !redirect_valid
                       && (occupancy < OW'(FIFO_DEPTH));
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    // Returned data lands one cycle after acceptance unless a redirect has invalidated it.
    assign push       = inflight_reg && !redirect_take && (state_reg != FLUSH);
    assign push_entry = '{pc: tag_reg, instr: imem_rdata};

    // Next-PC mux: reset/boot seed, then redirect, then sequential advance, else hold.
    always_comb begin
        pc_next = pc_q;
        if (reset || (state_reg == BOOT)) begin
            pc_next = RESET_ADDR;
        end else if (redirect_take) begin
            pc_next = align_word(redirect_target);
        end else if (accept) begin
            pc_next = pc_q + 32'(INSTR_BYTES);
        end
    end

    // Sequencer state, in-flight tracking and the registered misalignment pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            inflight_reg <= 1'b0;
            tag_reg      <= '0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT:    state_reg <= RUN;
                RUN:     state_reg <= redirect_valid ? FLUSH : RUN;
                FLUSH:   state_reg <= redirect_valid ? FLUSH : RUN;
                default: state_reg <= BOOT;
            endcase
            inflight_reg <= accept;
            if (accept) begin
                tag_reg <= pc_q;
            end
            misalign_reg <= redirect_take && (redirect_target[1:0] != 2'b00);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop && !redirect_take),
        .flush      (redirect_take),
        .count      (fifo_count),
        .head_valid (fifo_valid),
        .head_data  (fifo_head)
    );

    assign inst_valid   = fifo_valid;
    assign inst_data    = fifo_head.instr;
    assign inst_pc      = fifo_head.pc;
    assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC register and an echo memory (data == address).
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign_err;

    int n_checks = 0;
    int n_fails  = 0;

    instruction_fetch #(
        .RESET_ADDR (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_q            (pc_q),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    // External program counter register.
    always @(posedge clk) pc_q <= pc_next;

    // Instruction memory returning the request address as data one cycle later.
    always @(posedge clk) imem_rdata <= (imem_req && imem_ready) ? imem_addr : 32'hDEAD_BEEF;

    // One line per instruction handed to decode.
    always @(negedge clk) begin
        if (inst_valid && inst_ready && !reset)
            $display("[%0t] decode takes pc=%h data=%h", $time, inst_pc, inst_data);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        imem_ready      = 1'b1;
        inst_ready      = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Test 1: reset state, then streaming at one instruction per cycle.
        tick(2);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_pc_next", pc_next, 32'h0);
        reset = 1'b0;
        #1;
        check("boot_req", 32'(imem_req), 32'd0);
        check("boot_pc_next", pc_next, 32'h0);
        tick(1);
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_pc_next", pc_next, 32'h4);
        tick(1);
        check("c2_valid", 32'(inst_valid), 32'd0);
        check("c2_addr", imem_addr, 32'h4);
        tick(1);
        check("c3_valid", 32'(inst_valid), 32'd1);
        check("c3_pc", inst_pc, 32'h0);
        check("c3_data", inst_data, 32'h0);
        tick(1);
        check("c4_pc", inst_pc, 32'h4);
        check("c4_data", inst_data, 32'h4);
        tick(1);
        check("c5_pc", inst_pc, 32'h8);

        // Test 2: decode stalls, buffer fills, fetch holds, then drains in order.
        reset      = 1'b1;
        inst_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_pc_next", pc_next, 32'h8);
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_pc", inst_pc, 32'h0);
        tick(1);
        check("stall2_req", 32'(imem_req), 32'd0);
        check("stall2_pc_next", pc_next, 32'h8);
        check("stall2_data", inst_data, 32'h0);
        inst_ready = 1'b1;
        #1;
        check("drain_req", 32'(imem_req), 32'd1);
        check("drain_addr", imem_addr, 32'h8);
        tick(1);
        check("drain_pc1", inst_pc, 32'h4);
        check("drain_addr1", imem_addr, 32'hC);
        tick(1);
        check("drain_pc2", inst_pc, 32'h8);
        tick(1);
        check("pre_redir_pc", inst_pc, 32'hC);

        // Test 3: redirect to 0x7AC with a read in flight.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_07AC;
        #1;
        check("redir_pc_next", pc_next, 32'h7AC);
        check("redir_req", 32'(imem_req), 32'd0);
        tick(1);
        redirect_valid = 1'b0;
        #1;
        check("flush_valid", 32'(inst_valid), 32'd0);
        check("flush_req", 32'(imem_req), 32'd0);
        check("flush_misalign", 32'(misalign_err), 32'd0);
        check("flush_pc_next", pc_next, 32'h7AC);
        tick(1);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h7AC);
        check("resume_valid", 32'(inst_valid), 32'd0);
        tick(1);
        check("resume_valid2", 32'(inst_valid), 32'd0);
        tick(1);
        check("redir_inst_valid", 32'(inst_valid), 32'd1);
        check("redir_inst_pc", inst_pc, 32'h7AC);
        check("redir_inst_data", inst_data, 32'h7AC);

        // Test 4: misaligned redirect target.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_07AE;
        #1;
        check("mis_pc_next", pc_next, 32'h7AC);
        tick(1);
        redirect_valid = 1'b0;
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_valid", 32'(inst_valid), 32'd0);
        tick(1);
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        check("mis_resume_addr", imem_addr, 32'h7AC);
        tick(2);
        check("mis_inst_pc", inst_pc, 32'h7AC);

        // Test 5: address wrap at the top of memory.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc_next", pc_next, 32'h0);
        tick(1);
        check("wrap_addr2", imem_addr, 32'h0);
        check("wrap_pc_next2", pc_next, 32'h4);
        tick(1);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick(1);
        check("wrap_inst_pc2", inst_pc, 32'h0);

        // Test 6: memory back-pressure for 3 cycles, then reset mid-stream.
        imem_ready = 1'b0;
        #1;
        check("bp_req", 32'(imem_req), 32'd1);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_pc_next", pc_next, 32'h8);
        tick(1);
        check("bp_addr2", imem_addr, 32'h8);
        check("bp_inst_pc", inst_pc, 32'h4);
        tick(1);
        check("bp_addr3", imem_addr, 32'h8);
        check("bp_no_push", 32'(inst_valid), 32'd0);
        check("bp_pc_next3", pc_next, 32'h8);
        tick(1);
        imem_ready = 1'b1;
        #1;
        check("bp_release_pc_next", pc_next, 32'hC);
        tick(1);
        check("bp_release_addr", imem_addr, 32'hC);
        tick(1);
        check("bp_inst_pc2", inst_pc, 32'h8);
        reset = 1'b1;
        #1;
        check("mid_rst_pc_next", pc_next, 32'h0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        tick(1);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_pc_next2", pc_next, 32'h0);
        reset = 1'b0;
        tick(1);
        check("rerun_addr", imem_addr, 32'h0);
        tick(2);
        check("rerun_inst_pc", inst_pc, 32'h0);
        check("rerun_valid", 32'(inst_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
